// File: rtl/mem_arbiter_6502.sv
// Two-master arbiter for the shared external memory port: the 6502 cache (m0) and a secondary master (m1).
// An uncontested start passes through combinationally. A lost m0 start is held in a one-deep pending slot.
`default_nettype none

module mem_arbiter_6502 #(
    parameter int BURST_LEN  = 8,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] m0_addr,
    input  logic        m0_en,
    input  logic        m0_wr,
    input  logic        m0_rburst,
    input  logic        m0_wburst,
    input  logic [7:0]  m0_wdata,
    output logic        m0_rdy,
    output logic [7:0]  m0_rdata,
    output logic [7:0]  m0_rdata0,
    output logic        m0_rdata_load,
    input  logic [23:0] m1_addr,
    input  logic        m1_en,
    input  logic        m1_wr,
    input  logic        m1_rburst,
    input  logic        m1_wburst,
    input  logic [7:0]  m1_wdata,
    output logic        m1_rdy,
    output logic [7:0]  m1_rdata,
    output logic [7:0]  m1_rdata0,
    output logic        m1_rdata_load,
    output logic [23:0] s_addr,
    output logic        s_en,
    output logic        s_wr,
    output logic        s_rburst,
    output logic        s_wburst,
    output logic [7:0]  s_wdata,
    input  logic        s_rdy,
    input  logic [7:0]  s_rdata,
    input  logic [7:0]  s_rdata0,
    input  logic        s_rdata_load
);

    localparam int CW = $clog2(BURST_LEN);

    typedef struct packed {
        logic [23:0] addr;
        logic        wr;
        logic        rburst;
        logic        wburst;
        logic [7:0]  wdata;
    } cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state, state_nx;
    cmd_t          cmd_q, pend_q, m0_cmd, m1_cmd, win_cmd, cur_cmd, s_cmd;
    logic          pend_v, rr, owner, cur_owner;
    logic [CW-1:0] bcnt;
    logic          grant, win, is_burst, done, pend_cap;

    assign m0_cmd = '{addr: m0_addr, wr: m0_wr, rburst: m0_rburst, wburst: m0_wburst, wdata: m0_wdata};
    assign m1_cmd = '{addr: m1_addr, wr: m1_wr, rburst: m1_rburst, wburst: m1_wburst, wdata: m1_wdata};

    // win: 0 selects m0 (live or pending), 1 selects m1
    always_comb begin
        grant = 1'b0;
        win   = 1'b0;
        if (state == IDLE) begin
            if (pend_v) begin
                grant = 1'b1;
            end else if (m0_en && m1_en) begin
                grant = 1'b1;
                win   = FIXED_PRIO ? 1'b0 : rr;
            end else if (m0_en || m1_en) begin
                grant = 1'b1;
                win   = m1_en;
            end
        end
    end

    assign win_cmd  = pend_v ? pend_q : (win ? m1_cmd : m0_cmd);
    assign is_burst = cmd_q.rburst | cmd_q.wburst;
    assign done     = (state == BUSY) && s_rdata_load && (!is_burst || bcnt == CW'(BURST_LEN - 1));
    assign pend_cap = m0_en && !(grant && !win) && !(state == BUSY && !owner) && !pend_v;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = BUSY;
            BUSY:    if (done)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr     <= 1'b0;
            owner  <= 1'b0;
            pend_v <= 1'b0;
            pend_q <= '0;
            cmd_q  <= '0;
            bcnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && grant) begin
                cmd_q <= win_cmd;
                owner <= win;
            end
            if (state == IDLE && pend_v) begin
                pend_v <= 1'b0;
            end else if (pend_cap) begin
                pend_v <= 1'b1;
                pend_q <= m0_cmd;
            end
            if (done) begin
                bcnt <= '0;
                if (!FIXED_PRIO) rr <= ~owner;
            end else if (state == BUSY && s_rdata_load && is_burst) begin
                bcnt <= bcnt + CW'(1);
            end
        end
    end

    // The grant path is combinational from the masters, so reset has to mask it directly
    assign s_en      = !rst && (state == BUSY || grant);
    assign cur_cmd   = (state == BUSY) ? cmd_q : win_cmd;
    assign s_cmd     = s_en ? cur_cmd : '0;
    assign cur_owner = (state == BUSY) ? owner : win;

    assign s_addr   = s_cmd.addr;
    assign s_wr     = s_cmd.wr;
    assign s_rburst = s_cmd.rburst;
    assign s_wburst = s_cmd.wburst;
    assign s_wdata  = s_cmd.wdata;

    assign m0_rdy        = s_en && s_rdy && !cur_owner;
    assign m1_rdy        = s_en && s_rdy && cur_owner;
    assign m0_rdata_load = !rst && (state == BUSY) && s_rdata_load && !owner;
    assign m1_rdata_load = !rst && (state == BUSY) && s_rdata_load && owner;
    assign m0_rdata      = s_rdata;
    assign m1_rdata      = s_rdata;
    assign m0_rdata0     = s_rdata0;
    assign m1_rdata0     = s_rdata0;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter_6502.sv
// Directed bench for mem_arbiter_6502: round-robin instance plus a fixed-priority instance on shared stimulus.
`default_nettype none

module tb_mem_arbiter_6502;

    logic        clk, rst;
    logic [23:0] m0_addr, m1_addr;
    logic        m0_en, m0_wr, m0_rburst, m0_wburst;
    logic        m1_en, m1_wr, m1_rburst, m1_wburst;
    logic [7:0]  m0_wdata, m1_wdata;
    logic        s_rdy, s_rdata_load;
    logic [7:0]  s_rdata, s_rdata0;

    logic        m0_rdy, m1_rdy, m0_rdata_load, m1_rdata_load;
    logic [7:0]  m0_rdata, m1_rdata, m0_rdata0, m1_rdata0;
    logic [23:0] s_addr;
    logic        s_en, s_wr, s_rburst, s_wburst;
    logic [7:0]  s_wdata;

    logic        fx_m0_rdy, fx_m1_rdy, fx_m0_rdata_load, fx_m1_rdata_load;
    logic [7:0]  fx_m0_rdata, fx_m1_rdata, fx_m0_rdata0, fx_m1_rdata0;
    logic [23:0] fx_s_addr;
    logic        fx_s_en, fx_s_wr, fx_s_rburst, fx_s_wburst;
    logic [7:0]  fx_s_wdata;

    typedef struct {
        logic [23:0] addr;
        logic        rburst;
    } start_t;

    start_t q0[$];
    start_t qf[$];
    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter_6502 #(.BURST_LEN(8), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_en(m0_en), .m0_wr(m0_wr), .m0_rburst(m0_rburst), .m0_wburst(m0_wburst),
        .m0_wdata(m0_wdata), .m0_rdy(m0_rdy), .m0_rdata(m0_rdata), .m0_rdata0(m0_rdata0),
        .m0_rdata_load(m0_rdata_load),
        .m1_addr(m1_addr), .m1_en(m1_en), .m1_wr(m1_wr), .m1_rburst(m1_rburst), .m1_wburst(m1_wburst),
        .m1_wdata(m1_wdata), .m1_rdy(m1_rdy), .m1_rdata(m1_rdata), .m1_rdata0(m1_rdata0),
        .m1_rdata_load(m1_rdata_load),
        .s_addr(s_addr), .s_en(s_en), .s_wr(s_wr), .s_rburst(s_rburst), .s_wburst(s_wburst),
        .s_wdata(s_wdata), .s_rdy(s_rdy), .s_rdata(s_rdata), .s_rdata0(s_rdata0),
        .s_rdata_load(s_rdata_load)
    );

    mem_arbiter_6502 #(.BURST_LEN(8), .FIXED_PRIO(1'b1)) dutf (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_en(m0_en), .m0_wr(m0_wr), .m0_rburst(m0_rburst), .m0_wburst(m0_wburst),
        .m0_wdata(m0_wdata), .m0_rdy(fx_m0_rdy), .m0_rdata(fx_m0_rdata), .m0_rdata0(fx_m0_rdata0),
        .m0_rdata_load(fx_m0_rdata_load),
        .m1_addr(m1_addr), .m1_en(m1_en), .m1_wr(m1_wr), .m1_rburst(m1_rburst), .m1_wburst(m1_wburst),
        .m1_wdata(m1_wdata), .m1_rdy(fx_m1_rdy), .m1_rdata(fx_m1_rdata), .m1_rdata0(fx_m1_rdata0),
        .m1_rdata_load(fx_m1_rdata_load),
        .s_addr(fx_s_addr), .s_en(fx_s_en), .s_wr(fx_s_wr), .s_rburst(fx_s_rburst), .s_wburst(fx_s_wburst),
        .s_wdata(fx_s_wdata), .s_rdy(s_rdy), .s_rdata(s_rdata), .s_rdata0(s_rdata0),
        .s_rdata_load(s_rdata_load)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_start(input bit f, input logic [23:0] addr, input logic rburst);
        start_t e;
        e.addr   = addr;
        e.rburst = rburst;
        if (f) qf.push_back(e);
        else   q0.push_back(e);
    endtask

    // Pops the next expected command start for one instance and compares it with the port
    task automatic check_start(input bit f, input string tag);
        start_t e;
        if ((f ? qf.size() : q0.size()) == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed a start check, expected queue empty", tag);
            return;
        end
        e = f ? qf.pop_front() : q0.pop_front();
        check({tag, "_en"},     f ? fx_s_en     : s_en,     32'd1);
        check({tag, "_addr"},   f ? fx_s_addr   : s_addr,   {8'd0, e.addr});
        check({tag, "_rburst"}, f ? fx_s_rburst : s_rburst, {31'd0, e.rburst});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clk = 0; rst = 1;
        m0_addr = 24'h001234; m0_en = 1; m0_wr = 0; m0_rburst = 0; m0_wburst = 0; m0_wdata = 0;
        m1_addr = 0; m1_en = 0; m1_wr = 0; m1_rburst = 0; m1_wburst = 0; m1_wdata = 0;
        s_rdy = 1; s_rdata = 0; s_rdata0 = 0; s_rdata_load = 0;
        #3;
        check("rst_s_en", s_en, 0);
        check("rst_s_addr", s_addr, 0);
        check("rst_m0_rdy", m0_rdy, 0);
        check("rst_fx_s_en", fx_s_en, 0);
        m0_en = 0;
        tick(); rst = 0; tick();

        // Uncontested m0 single read
        m0_en = 1; m0_addr = 24'h001234;
        push_start(0, 24'h001234, 0); push_start(1, 24'h001234, 0);
        #1;
        check_start(0, "m0_rd"); check_start(1, "fx_m0_rd");
        check("m0_rd_m0_rdy", m0_rdy, 1);
        check("m0_rd_m1_rdy", m1_rdy, 0);
        tick(); m0_en = 0; m0_addr = 24'hFFFFFF;
        #1; check("m0_rd_hold_addr", s_addr, 24'h001234);
        tick(); tick();
        s_rdata_load = 1; s_rdata0 = 8'hA5; s_rdata = 8'h5A;
        #1;
        check("m0_rd_load0", m0_rdata_load, 1);
        check("m0_rd_rdata0", m0_rdata0, 8'hA5);
        check("m0_rd_load1", m1_rdata_load, 0);
        check("m0_rd_bcast", m1_rdata0, 8'hA5);
        tick();
        #1;
        check("m0_rd_idle_en", s_en, 0);
        check("idle_load_dropped", m0_rdata_load, 0);
        s_rdata_load = 0;

        // m0 burst while m1 waits
        tick();
        m0_en = 1; m0_addr = 24'h000100; m0_rburst = 1;
        push_start(0, 24'h000100, 1); push_start(1, 24'h000100, 1);
        #1; check_start(0, "m0_burst"); check_start(1, "fx_m0_burst");
        tick();
        m0_en = 0; m0_rburst = 0;
        m1_en = 1; m1_addr = 24'h0ABCDE; m1_wr = 1; m1_wdata = 8'h3C;
        push_start(0, 24'h0ABCDE, 0); push_start(1, 24'h0ABCDE, 0);
        for (int i = 0; i < 8; i++) begin
            s_rdata_load = 1; s_rdata = 8'(i);
            #1;
            check($sformatf("burst_en_%0d", i), s_en, 1);
            check($sformatf("burst_addr_%0d", i), s_addr, 24'h000100);
            check($sformatf("burst_ld0_%0d", i), m0_rdata_load, 1);
            check($sformatf("burst_ld1_%0d", i), m1_rdata_load, 0);
            tick();
        end
        s_rdata_load = 0;
        #1;
        check_start(0, "m1_after_burst"); check_start(1, "fx_m1_after_burst");
        check("m1_wr", s_wr, 1);
        check("m1_wdata", s_wdata, 8'h3C);
        check("m1_rdy", m1_rdy, 1);
        check("m1_m0_rdy", m0_rdy, 0);
        tick(); s_rdata_load = 1;
        #1;
        check("m1_ld1", m1_rdata_load, 1);
        check("m1_ld0", m0_rdata_load, 0);
        tick(); s_rdata_load = 0; m1_en = 0; m1_wr = 0;
        #1; check("m1_done_idle", s_en, 0);

        // Pending replay of a lost m0 start
        tick();
        m1_en = 1; m1_addr = 24'h020000; m1_wr = 1; m1_wdata = 8'h77;
        push_start(0, 24'h020000, 0); push_start(1, 24'h020000, 0);
        #1; check_start(0, "m1_wr"); check_start(1, "fx_m1_wr");
        tick(); m0_en = 1; m0_addr = 24'h000208; m0_rburst = 1;
        push_start(0, 24'h000208, 1); push_start(1, 24'h000208, 1);
        #1; check("pend_busy_addr", s_addr, 24'h020000);
        tick(); m0_en = 0; m0_addr = 24'h00020B; m0_rburst = 0;
        tick(); s_rdata_load = 1;
        #1; check("pend_m1_ld", m1_rdata_load, 1);
        tick(); s_rdata_load = 0; m1_en = 0; m1_wr = 0;
        #1;
        check_start(0, "pend_replay"); check_start(1, "fx_pend_replay");
        check("pend_m0_rdy", m0_rdy, 1);
        for (int i = 0; i < 8; i++) begin
            tick(); s_rdata_load = 1;
        end
        tick(); s_rdata_load = 0;
        #1; check("pend_done_idle", s_en, 0);

        // Simultaneous starts, both priority modes
        tick(); rst = 1; #2; rst = 0; tick();
        m0_en = 1; m0_addr = 24'h000300; m1_en = 1; m1_addr = 24'h040000;
        push_start(0, 24'h000300, 0); push_start(1, 24'h000300, 0);
        #1;
        check_start(0, "sim1"); check_start(1, "fx_sim1");
        check("sim1_m1_rdy", m1_rdy, 0);
        tick(); m0_en = 0;
        tick(); s_rdata_load = 1;
        tick(); s_rdata_load = 0; m0_en = 1; m0_addr = 24'h000500;
        push_start(0, 24'h040000, 0); push_start(0, 24'h000500, 0);
        push_start(1, 24'h000500, 0); push_start(1, 24'h040000, 0);
        #1; check_start(0, "sim2_rr"); check_start(1, "fx_sim2");
        tick(); m0_en = 0;
        tick(); s_rdata_load = 1;
        #1;
        check("sim2_m1_ld", m1_rdata_load, 1);
        check("fx_sim2_m0_ld", fx_m0_rdata_load, 1);
        tick(); s_rdata_load = 0;
        #1; check_start(0, "sim2_replay"); check_start(1, "fx_sim2_m1");
        tick(); tick(); s_rdata_load = 1;
        #1;
        check("sim2_m0_ld", m0_rdata_load, 1);
        check("fx_sim2_m1_ld", fx_m1_rdata_load, 1);
        tick(); s_rdata_load = 0; m1_en = 0;
        #1;
        check("sim_idle", s_en, 0);
        check("fx_sim_idle", fx_s_en, 0);

        // Reset in the middle of a burst
        tick();
        m0_en = 1; m0_addr = 24'h000700; m0_rburst = 1;
        push_start(0, 24'h000700, 1); push_start(1, 24'h000700, 1);
        #1; check_start(0, "rb_first"); check_start(1, "fx_rb_first");
        tick(); m0_en = 0; m0_rburst = 0; s_rdata_load = 1;
        tick(); tick();
        tick(); s_rdata_load = 0;
        #2; rst = 1;
        #1;
        check("rb_rst_en", s_en, 0);
        check("rb_rst_addr", s_addr, 0);
        check("fx_rb_rst_en", fx_s_en, 0);
        s_rdata_load = 1;
        #1; check("rb_rst_ld", m0_rdata_load, 0);
        s_rdata_load = 0;
        tick(); rst = 0; tick();
        m0_en = 1; m0_addr = 24'h000800; m0_rburst = 1;
        push_start(0, 24'h000800, 1); push_start(1, 24'h000800, 1);
        #1; check_start(0, "rb_second"); check_start(1, "fx_rb_second");
        tick(); m0_en = 0; m0_rburst = 0;
        for (int i = 0; i < 8; i++) begin
            s_rdata_load = 1;
            #1;
            check($sformatf("rb_en_%0d", i), s_en, 1);
            check($sformatf("rb_ld_%0d", i), m0_rdata_load, 1);
            tick();
        end
        s_rdata_load = 0;
        #1;
        check("rb_done_idle", s_en, 0);
        check("fx_rb_done_idle", fx_s_en, 0);
        check("sb_empty", q0.size() + qf.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter_6502.md
# mem_arbiter_6502

Two-master arbiter that shares the single external memory port between the 6502 cache controller (master 0) and a secondary bus master (master 1, e.g. DMA or video fetch). An uncontested start is granted in the same cycle and passes through with zero added latency. Once granted, a transaction runs to completion, including 8-byte read bursts, before the port is re-arbitrated. Because the cache issues each command on a single-cycle start and does not wait for `mem_rdy`, a losing master-0 start is captured in a one-deep pending register and replayed. The block sits between the cache controller and the memory/SDRAM controller.

## Interface
- `BURST_LEN`, 8: beads per burst (power of 2, ≥2). The burst counter is `$clog2(BURST_LEN)` bits.
- `FIXED_PRIO`, 0:
  - 0: round-robin between masters.
  - 1: master 0 always wins a simultaneous start.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `m0_addr`/`m1_addr` in 24: command address.
- `m0_en`/`m1_en` in 1: request/command valid.
- `m0_wr`/`m1_wr` in 1: write command.
- `m0_rburst`/`m1_rburst` in 1: read burst of `BURST_LEN`.
- `m0_wburst`/`m1_wburst` in 1: write burst of `BURST_LEN`.
- `m0_wdata`/`m1_wdata` in 8: write data.
- `m0_rdy`/`m1_rdy` out 1: `s_rdy` gated to the current owner.
- `m0_rdata`/`m1_rdata` out 8: `s_rdata` broadcast to both masters.
- `m0_rdata0`/`m1_rdata0` out 8: `s_rdata0` broadcast to both masters.
- `m0_rdata_load`/`m1_rdata_load` out 1: `s_rdata_load` gated to the owner.
- `s_addr` out 24: command address to memory.
- `s_en` out 1: command valid to memory.
- `s_wr` out 1: write command to memory.
- `s_rburst` out 1: read burst to memory.
- `s_wburst` out 1: write burst to memory.
- `s_wdata` out 8: write data to memory.
- `s_rdy` in 1: memory status.
- `s_rdata` in 8: read data from memory.
- `s_rdata0` in 8: read data from memory.
- `s_rdata_load` in 1: one pulse per completed bead.

## Operation
**Port protocol (decided)**
- A command begins on a cycle with `s_en`=1 where the previous cycle had `s_en`=0 or carried the completing `s_rdata_load`.
- A single access (read or write) completes on its one `s_rdata_load`.
- A burst completes on its `BURST_LEN`th `s_rdata_load`.

**States**
- IDLE:
  - Start source priority: pend0, then the live start(s), resolved by the `rr` pointer (or by `FIXED_PRIO`).
  - The winner's command drives `s_*` combinationally, `s_en`=1.
  - The command (addr, wr, rburst, wburst, wdata) is latched into `cmd_q`, owner is set, and the state goes to BUSY.
  - If there is no request, `s_en`=0.
- BUSY:
  - `s_*` are driven from `cmd_q`, `s_en`=1. Requester `en`, `addr` and `wdata` changes are ignored.
  - `bcnt` increments on each `s_rdata_load` for burst commands.
  - Completion is `s_rdata_load` && (!burst || `bcnt`==`BURST_LEN`-1).
  - On completion: go to IDLE; if `FIXED_PRIO`=0, `rr` points to the non-owner; clear `bcnt`.

**Pending capture**
- pend0 captures `m0`'s command when all of the following hold:
  - `m0_en`=1 and `m0` is not granted this cycle,
  - `m0` is not the BUSY owner,
  - pend0 is empty.
- pend0 wins the next IDLE cycle unconditionally (it has already lost once). It clears when granted.
- While pend0 is full, further `m0_en` is ignored.
- `m1` has no pending register. `m1` must hold `en` and its command stable until `m1_rdata_load` completes it.

**Gating**
- Non-owner `rdata_load` and `rdy` are 0.
- `rdata`/`rdata0` are pass-through to both masters.

## Timing
**Reset values**
- State IDLE, `rr`=0 (`m0` preferred), pend0 empty, `bcnt`=0, `cmd_q`=0.
- All `s_*` outputs and all gated outputs are 0 while in reset.

**Latency**
- Uncontested start: 0 cycles (combinational `m0`/`m1` → `s_*` path in IDLE).
- Contested start: loser starts in the cycle after the winner's completion.

**Boundary conditions**
- Completion and a new request in the same cycle: the request is granted in the next cycle, which is IDLE.
- Completion cycle: `s_en` remains 1. Downstream sees the new command per the protocol rule.
- `m0` start while pend0 is full: cannot occur for a compliant cache, and is dropped.
- `bcnt` wraps to 0 only on completion. Loads received in IDLE are ignored and not forwarded.
- Reset mid-transaction: immediate abort to reset values. No completion pulse is issued to either master.

## Test plan
- **Reset:** assert `rst` mid-cycle → all outputs 0 asynchronously; after release, IDLE with `rr`=0.
- **Uncontested `m0` read:** `m0` read at 0x001234 → same cycle `s_en`=1, `s_addr`=0x001234. Memory returns 0xA5 with `s_rdata_load` 3 cycles later → `m0_rdata_load`=1, `m0_rdata0`=0xA5, `m1_rdata_load`=0; IDLE the next cycle.
- **`m0` burst with `m1` waiting:** `m0` rburst at 0x000100, `m1_en` asserted during the burst → 8 loads reach `m0` only; `m1` is granted in the cycle after the 8th load with `s_addr`=`m1_addr`.
- **Pending replay:** `m1` write to 0x020000 in BUSY; `m0` pulses `en` one cycle with 0x000208/rburst, then changes `m0_addr` to 0x00020B → after `m1`'s load, `s_addr`=0x000208, `s_rburst`=1.
- **Simultaneous starts:** `FIXED_PRIO`=0, both start together, twice → first `m0` wins and `m1` is served next (`rr` → `m1`). Second round: `m1` wins and `m0` is pend0-replayed after it. With `FIXED_PRIO`=1, `m0` wins both rounds.
- **Reset mid-burst:** `rst` after 3 burst loads → `s_en`=0 immediately. A following `m0` burst completes after exactly 8 loads.
